// File: rtl/vx_ti_node_fetch_if.sv
// Word-granular cache read port used by the T&I node fetch unit.
// The fetch unit is the master: it issues requests and sinks responses.
interface vx_ti_node_fetch_if #(
    parameter int WORD_BITS = 32,
    parameter int TAG_BITS  = 4
);
    logic                 cache_req_valid;
    logic [31:0]          cache_req_addr;
    logic [TAG_BITS-1:0]  cache_req_tag;
    logic                 cache_req_ready;
    logic                 cache_rsp_valid;
    logic [WORD_BITS-1:0] cache_rsp_data;
    logic [TAG_BITS-1:0]  cache_rsp_tag;

    modport master (
        output cache_req_valid, cache_req_addr, cache_req_tag,
        input  cache_req_ready, cache_rsp_valid, cache_rsp_data, cache_rsp_tag
    );

    modport slave (
        input  cache_req_valid, cache_req_addr, cache_req_tag,
        output cache_req_ready, cache_rsp_valid, cache_rsp_data, cache_rsp_tag
    );
endinterface

// File: rtl/vx_ti_node_fetch.sv
// Fetches one BVH node as a burst of word reads and assembles the payload;
// responses may return out of order and are placed by tag.
//
// state | meaning
// IDLE  | waiting for start, ready_out high
// ISSUE | issuing word requests 0..N-1 to the cache
// WAIT  | all words issued, collecting outstanding responses
// DONE  | payload complete, valid_out pulse
module vx_ti_node_fetch #(
    parameter int DATA_BITS = 384,
    parameter int WORD_BITS = 32,
    parameter int TAG_BITS  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [31:0]          mem_addr,
    input  logic [5:0]           mem_size,
    output logic [DATA_BITS-1:0] mem_data,
    output logic                 valid_out,
    output logic                 ready_out,
    output logic                 size_err,
    vx_ti_node_fetch_if.master   cache
);
    localparam int NUM_WORDS = DATA_BITS / WORD_BITS;
    localparam int CNT_BITS  = $clog2(NUM_WORDS + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]           state;
    logic [31:0]          baseAddr;
    logic [CNT_BITS-1:0]  wordCnt;
    logic [CNT_BITS-1:0]  issueIdx;
    logic [NUM_WORDS-1:0] pending;
    logic [NUM_WORDS-1:0] issueMask;
    logic [NUM_WORDS-1:0] rspMask;
    logic [NUM_WORDS-1:0] pendingNext;
    logic [DATA_BITS-1:0] memData;
    logic                 sizeErr;
    logic                 issueFire;
    logic                 lastIssue;
    logic [6:0]           sizeRound;
    logic                 reqClamp;
    logic [CNT_BITS-1:0]  reqWords;

    assign sizeRound = (7'(mem_size) + 7'd3) >> 2;
    assign reqClamp  = sizeRound > 7'(NUM_WORDS);
    assign reqWords  = reqClamp ? CNT_BITS'(NUM_WORDS) : CNT_BITS'(sizeRound);

    assign issueFire = (state == ISSUE) && cache.cache_req_ready;
    assign lastIssue = issueFire && (issueIdx == wordCnt - CNT_BITS'(1));

    // A response may target the word being accepted this very cycle, so the
    // hit check looks at the pending set including this cycle's issue.
    assign issueMask   = issueFire ? (NUM_WORDS'(1) << issueIdx) : '0;
    assign rspMask     = {NUM_WORDS{cache.cache_rsp_valid}}
                       & (NUM_WORDS'(1) << cache.cache_rsp_tag)
                       & (pending | issueMask);
    assign pendingNext = (pending | issueMask) & ~rspMask;

    assign cache.cache_req_valid = (state == ISSUE);
    assign cache.cache_req_addr  = baseAddr + (32'(issueIdx) << 2);
    assign cache.cache_req_tag   = TAG_BITS'(issueIdx);

    assign mem_data  = memData;
    assign valid_out = (state == DONE);
    assign ready_out = (state == IDLE);
    assign size_err  = sizeErr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            baseAddr <= '0;
            wordCnt  <= '0;
            issueIdx <= '0;
            pending  <= '0;
            memData  <= '0;
            sizeErr  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        baseAddr <= mem_addr & ~32'h3;
                        wordCnt  <= reqWords;
                        issueIdx <= '0;
                        pending  <= '0;
                        memData  <= '0;
                        sizeErr  <= reqClamp;
                        state    <= (mem_size == 6'd0) ? DONE : ISSUE;
                    end
                end
                ISSUE: begin
                    pending <= pendingNext;
                    if (issueFire) begin
                        issueIdx <= issueIdx + CNT_BITS'(1);
                        if (lastIssue)
                            state <= (pendingNext == '0) ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    pending <= pendingNext;
                    if (pendingNext == '0)
                        state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase

            for (int k = 0; k < NUM_WORDS; k++) begin
                if (rspMask[k])
                    memData[k*WORD_BITS +: WORD_BITS] <= cache.cache_rsp_data;
            end
        end
    end
endmodule

// File: doc/vx_ti_node_fetch.md
VX_TI_NODE_FETCH -- requirements
Module: vx_ti_node_fetch

Interface
REQ-001 SHALL have parameter DATA_BITS, default 384, meaning the maximum node payload returned per request (48 bytes).
REQ-002 SHALL have parameter WORD_BITS, default 32, meaning the width of one cache word.
REQ-003 SHALL have parameter TAG_BITS, default 4, meaning the cache tag width; the tag carries the word index within the request.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  request strobe from the T&I traversal FSM.
REQ-007 mem_addr  in  32  byte address of the node.
REQ-008 mem_size  in  6  request length in bytes, 0..63.
REQ-009 mem_data  out  DATA_BITS  assembled node payload.
REQ-010 valid_out  out  1  one-cycle pulse: mem_data is complete.
REQ-011 ready_out  out  1  unit idle; the next start is accepted.
REQ-012 cache_req_valid / cache_req_addr[31:0] / cache_req_tag[TAG_BITS-1:0]  out  word read request.
REQ-013 cache_req_ready  in  1  cache accepts the request this cycle.
REQ-014 cache_rsp_valid / cache_rsp_data[WORD_BITS-1:0] / cache_rsp_tag[TAG_BITS-1:0]  in  word response; the unit always accepts it (no backpressure).

Function
REQ-015 FSM states are IDLE, ISSUE, WAIT and DONE; ready_out is 1 only in IDLE.
REQ-016 In IDLE, start=1 latches the address (bits [1:0] forced to 0) and the word count N, clears mem_data to 0 and the pending mask, and moves to ISSUE; when mem_size=0 it moves directly to DONE.
REQ-017 Word count rule: N = ceil(mem_size/4), clamped to DATA_BITS/WORD_BITS (12); the clamp sets a sticky size_err flag, readable as an output, that is cleared by the next accepted start.
REQ-018 start while not in IDLE is ignored and has no side effects.
REQ-019 ISSUE drives cache_req_valid=1 with addr = base + 4*i and tag = i for i = 0..N-1; i advances only on cache_req_valid && cache_req_ready; addr and tag hold stable while stalled.
REQ-020 Address arithmetic is 32-bit and wraps modulo 2^32 with no error.
REQ-021 Issuing word i sets pending bit i; after word N-1 is accepted, the FSM moves to WAIT (or to DONE if every bit has already returned).
REQ-022 cache_rsp_valid with tag t and pending[t]=1 writes mem_data[WORD_BITS*t +: WORD_BITS] and clears pending[t]; responses may arrive out of order.
REQ-023 A response whose tag is not pending (stale or duplicate) is discarded and changes no state.
REQ-024 A response arriving in the same cycle its request is accepted is handled correctly; issue and capture are independent.
REQ-025 Once all N words are issued and pending is 0, the FSM enters DONE on the next edge; DONE asserts valid_out for exactly 1 cycle and returns to IDLE.
REQ-026 mem_data holds stable from valid_out until the next accepted start; bits above WORD_BITS*N read 0.
REQ-027 Minimum latency with a cache that has ready=1 and a same-cycle response: start accepted at cycle 0; valid_out at cycle N+1.
REQ-028 At most one request is in flight at a time; the outstanding words per request are at most 12.

Reset
REQ-029 Asserting reset (low) at any time forces IDLE, ready_out=1, valid_out=0, cache_req_valid=0, mem_data=0, pending=0, size_err=0 and i=0, asynchronously.
REQ-030 Responses returning after reset are discarded under REQ-023, because pending=0.
REQ-031 Deassertion is synchronous to clk; the first start is accepted on the first edge after deassertion.

Verification
REQ-032 addr=0x1000, size=32, cache ready=1 with in-order zero-latency responses returning 0xA0+i -> 8 requests to 0x1000..0x101C with tags 0..7; valid_out at cycle 9; mem_data[255:0] = words 0xA0..0xA7; upper 128 bits are 0.
REQ-033 addr=0x2002, size=48, responses returned in reverse tag order with 3-cycle latency -> first address 0x2000, 12 words placed by tag, exactly one valid_out pulse.
REQ-034 size=4, cache_req_ready low for 5 cycles -> addr and tag held constant while stalled; valid_out only after the single response; start pulses during busy are ignored.
REQ-035 size=0 -> no cache request; valid_out on cycle 1 with mem_data=0; size=60 -> 12 words issued and size_err=1.
REQ-036 Reset asserted while 6 of 8 words are pending, then 6 late responses arrive -> all are discarded; ready_out=1, mem_data=0; a following size=4 request completes correctly.
REQ-037 addr=0xFFFFFFF8, size=16 -> request addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004.
